// File: rtl/ntt_result_unpacker.sv
// Output stage of the NTT1024 core: captures the interleaved dout0 stream into natural order,
// applies the final conditional subtract of q and replays the ring over a valid/ready port.
module ntt_result_unpacker #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic [11:0]          ring_size,
    input  logic [DATA_W-1:0]    q,
    input  logic                 nd_done,
    input  logic                 nd_valid,
    input  logic [DATA_W-1:0]    nd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [MAX_DEPTH-1:0] out_index,
    output logic                 busy,
    output logic                 unpack_done,
    output logic [1:0]           err
);

    localparam int unsigned AW    = MAX_DEPTH;
    localparam int unsigned DEPTH = 1 << MAX_DEPTH;
    localparam logic [11:0] DEPTH_W = 12'(DEPTH);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDrain} state_t;

    state_t state, state_nxt;

    logic [AW:0]        n_reg;
    logic [DATA_W-1:0]  q_reg;
    logic [AW-1:0]      beat_cnt;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic [AW:0]        rd_cnt;
    logic               rd_vld;
    logic [AW-1:0]      rd_idx;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               legal_n;
    logic               arm_ok;
    logic [AW-1:0]      last_idx;
    logic [AW-1:0]      half;
    logic [AW-1:0]      beat_addr;
    logic [DATA_W-1:0]  reduced;
    logic               cap_fire;
    logic               last_beat;
    logic               hs;
    logic               move;
    logic               rd_issue;
    logic               last_hs;

    always_comb begin
        legal_n   = (ring_size >= 12'd2) && (ring_size <= DEPTH_W) &&
                    ((ring_size & (ring_size - 12'd1)) == 12'd0);
        arm_ok    = arm && (state == StIdle) && legal_n;
        last_idx  = n_reg[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
        half      = n_reg[AW:1];
        // Even beats fill the lower half, odd beats the upper half.
        beat_addr = beat_cnt[0] ? ({1'b0, beat_cnt[AW-1:1]} + half) : {1'b0, beat_cnt[AW-1:1]};
        reduced   = (nd_data >= q_reg) ? (nd_data - q_reg) : nd_data;
        cap_fire  = (state == StCapture) && nd_valid;
        last_beat = cap_fire && (beat_cnt == last_idx);
        hs        = out_valid && out_ready;
        // Prefetched word moves to the output register whenever it is empty or being consumed.
        move      = rd_vld && (!out_valid || hs);
        rd_issue  = (state == StDrain) && (rd_cnt < n_reg) && (!rd_vld || move);
        last_hs   = (state == StDrain) && hs && (out_index == last_idx);
        busy      = (state != StIdle);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            StIdle:    if (arm_ok)    state_nxt = StArmed;
            StArmed:   if (nd_done)   state_nxt = StCapture;
            StCapture: if (last_beat) state_nxt = StDrain;
            StDrain:   if (last_hs)   state_nxt = StIdle;
            default:                  state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            n_reg       <= '0;
            q_reg       <= '0;
            beat_cnt    <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_cnt      <= '0;
            rd_vld      <= 1'b0;
            rd_idx      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            unpack_done <= 1'b0;
            err         <= 2'b00;
        end else begin
            state       <= state_nxt;
            unpack_done <= last_hs;
            wr_en       <= cap_fire;
            if (cap_fire) begin
                wr_addr  <= beat_addr;
                wr_data  <= reduced;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (arm_ok) begin
                n_reg    <= ring_size[AW:0];
                q_reg    <= q;
                beat_cnt <= '0;
                rd_cnt   <= '0;
            end
            if (arm && (state == StIdle) && !legal_n) err[1] <= 1'b1;
            if ((state == StDrain) && nd_valid)      err[0] <= 1'b1;
            if (rd_issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                rd_idx <= rd_cnt[AW-1:0];
            end
            if (rd_issue)  rd_vld <= 1'b1;
            else if (move) rd_vld <= 1'b0;
            if (move) begin
                out_valid <= 1'b1;
                out_data  <= rd_data;
                out_index <= rd_idx;
            end else if (hs) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Plain synchronous RAM without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_issue) rd_data <= mem[rd_cnt[AW-1:0]];
    end

endmodule

// File: tb/tb_ntt_result_unpacker.sv
// Self-checking bench for ntt_result_unpacker: model of the natural-order reduced output,
// a per-cycle compare process and directed runs with literal pins.
module tb_ntt_result_unpacker;

    localparam int DW = 32;
    localparam int MD = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm;
    logic [11:0]   ring_size;
    logic [DW-1:0] q;
    logic          nd_done;
    logic          nd_valid;
    logic [DW-1:0] nd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [MD-1:0] out_index;
    logic          busy;
    logic          unpack_done;
    logic [1:0]    err;

    ntt_result_unpacker #(.DATA_W(DW), .MAX_DEPTH(MD)) dut (
        .clk(clk), .reset(reset), .arm(arm), .ring_size(ring_size), .q(q),
        .nd_done(nd_done), .nd_valid(nd_valid), .nd_data(nd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .busy(busy), .unpack_done(unpack_done), .err(err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   beats [0:1023];
    logic [31:0]   got   [0:1023];
    int            model_n = 2;
    logic [31:0]   model_q = 0;
    int            exp_k = 0;
    int            done_cnt = 0;
    bit            ready_mode = 0;
    int            rcyc = 0;
    bit            hold_p = 0;
    logic [31:0]   hold_d;
    logic [MD-1:0] hold_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Natural index k holds beat 2k (lower half) or 2(k-N/2)+1 (upper half), reduced once by q.
    function automatic logic [31:0] exp_val(input int k);
        int m;
        logic [31:0] d;
        m = (k < model_n / 2) ? 2 * k : 2 * (k - model_n / 2) + 1;
        d = beats[m];
        return (d >= model_q) ? d - model_q : d;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            hold_p = 0;
        end else begin
            if (hold_p) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", out_data, hold_d);
                check("stall_index", {22'd0, out_index}, {22'd0, hold_i});
            end
            if (out_valid && out_ready) begin
                if (exp_k < model_n) begin
                    check("out_index", {22'd0, out_index}, 32'(exp_k));
                    check("out_data", out_data, exp_val(exp_k));
                    got[out_index] = out_data;
                end else begin
                    check("extra_handshake", 32'(exp_k), 32'(model_n - 1));
                end
                exp_k++;
            end
            if (unpack_done) done_cnt++;
            hold_p = out_valid && !out_ready;
            hold_d = out_data;
            hold_i = out_index;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) out_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
            else            out_ready = 1'b1;
            rcyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_ring(input int n, input logic [31:0] qq);
        ring_size = 12'(n);
        q         = qq;
        arm       = 1'b1;
        tick();
        arm       = 1'b0;
    endtask

    // nd_done arrives with a garbage beat that must be dropped.
    task automatic capture(input int nbeats, input bit gaps);
        nd_done  = 1'b1;
        nd_valid = 1'b1;
        nd_data  = 32'hDEADBEEF;
        tick();
        nd_done  = 1'b0;
        nd_valid = 1'b0;
        for (int m = 0; m < nbeats; m++) begin
            nd_valid = 1'b1;
            nd_data  = beats[m];
            tick();
            nd_valid = 1'b0;
            if (gaps && (m % 2 == 1)) repeat (3) tick();
        end
    endtask

    task automatic wait_done();
        int t;
        int start;
        t = 0;
        start = done_cnt;
        while (done_cnt == start && t < 5000) begin
            tick();
            t++;
        end
        check("done_timeout", {31'd0, (t < 5000)}, 32'd1);
        check("handshake_count", 32'(exp_k), 32'(model_n));
        check("done_count", 32'(done_cnt - start), 32'd1);
        tick();
        check("done_pulse_width", {31'd0, unpack_done}, 32'd0);
        check("busy_after_drain", {31'd0, busy}, 32'd0);
        check("valid_after_drain", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run(input int n, input logic [31:0] qq, input int nbeats, input bit gaps);
        model_n = n;
        model_q = qq;
        exp_k   = 0;
        arm_ring(n, qq);
        check("busy_after_arm", {31'd0, busy}, 32'd1);
        capture(nbeats, gaps);
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; arm = 1'b0; ring_size = '0; q = '0;
        nd_done = 1'b0; nd_valid = 1'b0; nd_data = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_index", {22'd0, out_index}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_unpack_done", {31'd0, unpack_done}, 32'd0);
        check("rst_err", {30'd0, err}, 32'd0);

        // Case 1: identity data, contiguous beats.
        for (int m = 0; m < 256; m++) beats[m] = 32'(m);
        run(256, 32'd3329, 256, 1'b0);
        check("c1_got0", got[0], 32'd0);
        check("c1_got1", got[1], 32'd2);
        check("c1_got127", got[127], 32'd254);
        check("c1_got128", got[128], 32'd1);
        check("c1_got255", got[255], 32'd255);

        // Case 2: single conditional subtract.
        for (int m = 0; m < 256; m++)
            beats[m] = (m % 3 == 0) ? 32'd3329 : (m % 3 == 1) ? 32'd3330 : 32'd6657;
        run(256, 32'd3329, 256, 1'b0);
        check("c2_got0", got[0], 32'd0);
        check("c2_got128", got[128], 32'd1);
        check("c2_got1", got[1], 32'd3328);

        // Case 3: back-pressure 1,0,0,1.
        for (int m = 0; m < 256; m++) beats[m] = 32'(m * 13 + 5);
        ready_mode = 1;
        run(256, 32'd3329, 256, 1'b0);
        ready_mode = 0;
        check("c3_got128", got[128], 32'd18);

        // Case 4: grouped beats with gaps.
        for (int m = 0; m < 256; m++) beats[m] = 32'(m);
        run(256, 32'd3329, 256, 1'b1);
        check("c4_got127", got[127], 32'd254);
        check("c4_got129", got[129], 32'd3);

        // Case 5: extra beats, then illegal ring size.
        for (int m = 0; m < 260; m++) beats[m] = 32'(1000 + m);
        run(256, 32'd3329, 260, 1'b0);
        check("c5_err0", {31'd0, err[0]}, 32'd1);
        check("c5_got255", got[255], 32'd1255);
        arm_ring(300, 32'd3329);
        tick();
        check("c5_busy_illegal", {31'd0, busy}, 32'd0);
        check("c5_err_sticky", {30'd0, err}, 32'd3);

        // Case 6: reset mid-capture, then full N=1024 run.
        for (int m = 0; m < 1024; m++) beats[m] = 32'(m);
        arm_ring(1024, 32'd3329);
        capture(100, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("c6_busy_reset", {31'd0, busy}, 32'd0);
        check("c6_err_reset", {30'd0, err}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        run(1024, 32'd3329, 1024, 1'b0);
        check("c6_got0", got[0], 32'd0);
        check("c6_got511", got[511], 32'd1022);
        check("c6_got512", got[512], 32'd1);
        check("c6_got1023", got[1023], 32'd1023);
        check("c6_err_clean", {30'd0, err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
